// File: rtl/sdram_target.sv
// sdram_target: SDR SDRAM responder backed by on-chip RAM, with protocol checking and CAS-latency-timed read data.
// Ports: clk/rst_n (async active-low); clock_enable freezes everything when low;
// cs_n/ras_n/cas_n/we_n command strobes; addr row/col/mode (A10 = all / auto-precharge);
// bank_addr bank select; data_in/data_mask write data and mask; data_out/data_oe read data;
// init_done after first legal MRS; err/err_code first sticky violation; refresh_count accepted REFs.
module sdram_target #(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 10,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = 13,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int TRCD           = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clock_enable,
    input  logic                     cs_n,
    input  logic                     ras_n,
    input  logic                     cas_n,
    input  logic                     we_n,
    input  logic [SDRADDR_WIDTH-1:0] addr,
    input  logic [BANK_WIDTH-1:0]    bank_addr,
    input  logic [7:0]               data_in,
    input  logic                     data_mask,
    output logic [7:0]               data_out,
    output logic                     data_oe,
    output logic                     init_done,
    output logic                     err,
    output logic [2:0]               err_code,
    output logic [15:0]              refresh_count
);
    localparam int NB  = 1 << BANK_WIDTH;
    localparam int CW  = $clog2(TRCD + 1);
    localparam int A10 = 10;
    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS} cmd_t;
    cmd_t                      cmd;
    logic [NB-1:0]             active;
    logic [ROW_WIDTH-1:0]      row [NB];
    logic [CW-1:0]             cnt [NB];
    logic [2:0]                cl;
    logic [7:0]                mem [2**MEM_ADDR_WIDTH];
    logic [7:0]                rd_data;
    logic [7:0]                s2_d;
    logic                      v0;
    logic                      v0_cl2;
    logic                      s2_v;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic                      bank_ok;
    logic                      cnt_busy;
    logic                      rw;
    logic                      any_active;
    logic                      mrs_bad;
    logic [2:0]                ecode;

    always_comb begin
        cmd = (!clock_enable || cs_n)       ? C_NOP :
              {ras_n, cas_n, we_n} == 3'b011 ? C_ACT :
              {ras_n, cas_n, we_n} == 3'b101 ? C_RD  :
              {ras_n, cas_n, we_n} == 3'b100 ? C_WR  :
              {ras_n, cas_n, we_n} == 3'b010 ? C_PRE :
              {ras_n, cas_n, we_n} == 3'b001 ? C_REF :
              {ras_n, cas_n, we_n} == 3'b000 ? C_MRS : C_NOP;
    end

    assign idx        = MEM_ADDR_WIDTH'({bank_addr, row[bank_addr], addr[COL_WIDTH-1:0]});
    assign bank_ok    = active[bank_addr];
    assign cnt_busy   = cnt[bank_addr] != '0;
    assign rw         = cmd == C_RD || cmd == C_WR;
    assign any_active = |active;
    assign mrs_bad    = (addr[6:4] != 3'd2 && addr[6:4] != 3'd3) || addr[2:0] != 3'd0;

    // Command-specific violations take priority over the not-initialised code.
    assign ecode = (cmd == C_ACT && bank_ok)   ? 3'd1 :
                   (rw && !bank_ok)            ? 3'd2 :
                   (rw && cnt_busy)            ? 3'd3 :
                   (cmd == C_REF && any_active) ? 3'd4 :
                   (cmd == C_MRS && any_active) ? 3'd5 :
                   (cmd == C_MRS && mrs_bad)   ? 3'd6 :
                   ((cmd == C_ACT || rw || cmd == C_REF) && !init_done) ? 3'd7 : 3'd0;

    // Block RAM: no reset, synchronous read at the command edge.
    always_ff @(posedge clk) begin
        if (clock_enable) begin
            if (cmd == C_WR && bank_ok && !data_mask) mem[idx] <= data_in;
            if (cmd == C_RD && bank_ok) rd_data <= mem[idx];
        end
    end

    // Read data: CL=2 goes rd_data -> data_out, CL=3 adds the s2 stage. MRS needs all
    // banks idle, so a CL change can never make both paths land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active        <= '0;
            for (int i = 0; i < NB; i++) begin
                row[i] <= '0;
                cnt[i] <= '0;
            end
            cl            <= 3'd3;
            init_done     <= 1'b0;
            err           <= 1'b0;
            err_code      <= 3'd0;
            refresh_count <= 16'd0;
            v0            <= 1'b0;
            v0_cl2        <= 1'b0;
            s2_v          <= 1'b0;
            s2_d          <= 8'd0;
            data_oe       <= 1'b0;
            data_out      <= 8'd0;
        end else if (clock_enable) begin
            for (int i = 0; i < NB; i++)
                if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
            if (cmd == C_ACT) begin
                active[bank_addr] <= 1'b1;
                row[bank_addr]    <= addr[ROW_WIDTH-1:0];
                cnt[bank_addr]    <= CW'(TRCD - 1);
            end
            if (rw && bank_ok && addr[A10]) active[bank_addr] <= 1'b0;
            if (cmd == C_PRE) begin
                if (addr[A10]) active <= '0;
                else active[bank_addr] <= 1'b0;
            end
            if (cmd == C_REF) refresh_count <= refresh_count + 16'd1;
            if (cmd == C_MRS && !any_active && !mrs_bad) begin
                cl        <= addr[6:4];
                init_done <= 1'b1;
            end
            if (!err && ecode != 3'd0) begin
                err      <= 1'b1;
                err_code <= ecode;
            end
            v0       <= cmd == C_RD && bank_ok;
            v0_cl2   <= cl == 3'd2;
            s2_v     <= v0 && !v0_cl2;
            s2_d     <= rd_data;
            data_oe  <= s2_v || (v0 && v0_cl2);
            data_out <= s2_v ? s2_d : (v0 && v0_cl2) ? rd_data : 8'd0;
        end
    end
endmodule

// File: tb/tb_sdram_target.sv
// tb_sdram_target: table-driven, directed and randomized checks of sdram_target against a behavioural model.
module tb_sdram_target;
    localparam int TRCD = 2;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000, DES = 4'b1111;

    logic        clk = 0, rst_n = 0, ce = 1, data_mask = 0;
    logic        cs_n = 1, ras_n = 1, cas_n = 1, we_n = 1;
    logic [12:0] addr = '0;
    logic [1:0]  bank_addr = '0;
    logic [7:0]  data_in = '0, data_out;
    logic        data_oe, init_done, err;
    logic [2:0]  err_code;
    logic [15:0] refresh_count;

    always #5 clk = ~clk;

    sdram_target dut (
        .clk(clk), .rst_n(rst_n), .clock_enable(ce),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .addr(addr), .bank_addr(bank_addr), .data_in(data_in), .data_mask(data_mask),
        .data_out(data_out), .data_oe(data_oe), .init_done(init_done),
        .err(err), .err_code(err_code), .refresh_count(refresh_count)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: t counts clock-enabled edges; reads are scheduled by due edge.
    bit         m_act [4];
    int         m_row [4];
    int         m_ready [4];
    int         m_cl, m_err, m_ref, t;
    bit         m_init;
    logic [7:0] mm [int];
    bit         sch_v [int];
    bit         sch_k [int];
    logic [7:0] sch_d [int];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_row[i] = 0; m_ready[i] = 0;
        end
        m_cl = 3; m_err = 0; m_ref = 0; t = 0; m_init = 0;
        sch_v.delete(); sch_k.delete(); sch_d.delete();
    endtask

    task automatic model_step(input logic [3:0] c, input logic [12:0] a, input int b,
                              input logic [7:0] d, input logic m);
        int e = 0;
        int idx;
        bit any;
        t++;
        any = m_act[0] | m_act[1] | m_act[2] | m_act[3];
        if (!c[3]) begin
            case (c[2:0])
                3'b011: begin
                    if (m_act[b]) e = 1;
                    else if (!m_init) e = 7;
                    m_act[b] = 1; m_row[b] = int'(a); m_ready[b] = t + TRCD;
                end
                3'b101, 3'b100: begin
                    if (!m_act[b]) e = 2;
                    else begin
                        if (t < m_ready[b]) e = 3;
                        else if (!m_init) e = 7;
                        idx = ((b << 23) | (m_row[b] << 10) | (int'(a) & 'h3ff)) & 'h7ff;
                        if (!c[0]) begin
                            if (!m) mm[idx] = d;
                        end else begin
                            sch_v[t + m_cl - 1] = 1;
                            sch_k[t + m_cl - 1] = mm.exists(idx);
                            if (mm.exists(idx)) sch_d[t + m_cl - 1] = mm[idx];
                        end
                        if (a[10]) m_act[b] = 0;
                    end
                end
                3'b010: begin
                    if (a[10]) for (int i = 0; i < 4; i++) m_act[i] = 0;
                    else m_act[b] = 0;
                end
                3'b001: begin
                    e = any ? 4 : !m_init ? 7 : 0;
                    m_ref = (m_ref + 1) % 65536;
                end
                3'b000: begin
                    if (any) e = 5;
                    else if ((a[6:4] != 2 && a[6:4] != 3) || a[2:0] != 0) e = 6;
                    else begin m_cl = int'(a[6:4]); m_init = 1; end
                end
                default: ;
            endcase
        end
        if (m_err == 0) m_err = e;
    endtask

    task automatic check_model();
        bit eoe;
        eoe = sch_v.exists(t);
        chk("data_oe", int'(data_oe), int'(eoe));
        if (eoe && sch_k[t]) chk("data_out", int'(data_out), int'(sch_d[t]));
        chk("err", int'(err), int'(m_err != 0));
        chk("err_code", int'(err_code), m_err);
        chk("init_done", int'(init_done), int'(m_init));
        chk("refresh_count", int'(refresh_count), m_ref);
    endtask

    task automatic tick(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b,
                        input logic [7:0] d, input logic m, input logic e);
        {cs_n, ras_n, cas_n, we_n} = c;
        addr = a; bank_addr = b; data_in = d; data_mask = m; ce = e;
        @(posedge clk);
        if (e) model_step(c, a, int'(b), d, m);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        model_reset();
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_oe", int'(data_oe), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_refresh_count", int'(refresh_count), 0);
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = NOP;
        ce = 1;
        rst_n = 1;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [12:0] a;
        logic [1:0]  b;
        logic [7:0]  d;
        logic        m;
        logic        eoe;
        logic [7:0]  edo;
        logic [2:0]  eec;
        logic        ein;
    } vec_t;
    vec_t vt [8];

    logic [3:0]  rc;
    logic [12:0] ra, col;
    int          r;

    initial begin
        vt[0] = '{MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[1] = '{ACT, 13'd5,   2'd1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[2] = '{NOP, 13'd0,   2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[3] = '{WR,  13'd3,   2'd1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[4] = '{RD,  13'd3,   2'd1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[5] = '{NOP, 13'd0,   2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[6] = '{NOP, 13'd0,   2'd0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b1};
        vt[7] = '{NOP, 13'd0,   2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        #1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(vt[i].c, vt[i].a, vt[i].b, vt[i].d, vt[i].m, 1'b1);
            chk($sformatf("vec%0d_oe", i), int'(data_oe), int'(vt[i].eoe));
            if (vt[i].eoe) chk($sformatf("vec%0d_data", i), int'(data_out), int'(vt[i].edo));
            chk($sformatf("vec%0d_err_code", i), int'(err_code), int'(vt[i].eec));
            chk($sformatf("vec%0d_init", i), int'(init_done), int'(vt[i].ein));
        end

        // CL=2 timing and masked write
        tick(PRE, 13'h400, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(MRS, 13'h220, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(ACT, 13'd5, 2'd1, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(RD, 13'd3, 2'd1, 8'h00, 1'b0, 1'b1);
        chk("cl2_oe_early", int'(data_oe), 0);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("cl2_oe", int'(data_oe), 1);
        chk("cl2_data", int'(data_out), 'hA5);
        tick(WR, 13'd3, 2'd1, 8'h3C, 1'b1, 1'b1);
        tick(RD, 13'd3, 2'd1, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("mask_oe", int'(data_oe), 1);
        chk("mask_data", int'(data_out), 'hA5);

        // READ to an idle bank, then ACT to an active bank keeps the first code
        do_reset();
        tick(MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(RD, 13'd0, 2'd2, 8'h00, 1'b0, 1'b1);
        chk("idle_rd_err", int'(err), 1);
        chk("idle_rd_code", int'(err_code), 2);
        for (int i = 0; i < 3; i++) begin
            tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
            chk("idle_rd_no_oe", int'(data_oe), 0);
        end
        tick(ACT, 13'd1, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(ACT, 13'd2, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("sticky_code", int'(err_code), 2);

        // tRCD violation still returns data
        do_reset();
        tick(MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(ACT, 13'd7, 2'd3, 8'h00, 1'b0, 1'b1);
        tick(RD, 13'd1, 2'd3, 8'h00, 1'b0, 1'b1);
        chk("trcd_code", int'(err_code), 3);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("trcd_oe", int'(data_oe), 1);

        // WRITE with auto-precharge closes the bank
        do_reset();
        tick(MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(ACT, 13'd7, 2'd3, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(WR, 13'h401, 2'd3, 8'h77, 1'b0, 1'b1);
        chk("ap_wr_ok", int'(err), 0);
        tick(RD, 13'd1, 2'd3, 8'h00, 1'b0, 1'b1);
        chk("ap_code", int'(err_code), 2);
        for (int i = 0; i < 3; i++) tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);

        // refresh counting, clock-enable freeze, reset mid-read
        do_reset();
        tick(MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(REF, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("ref_count", int'(refresh_count), 3);
        chk("ref_err", int'(err), 0);
        tick(ACT, 13'd5, 2'd1, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        tick(RD, 13'd3, 2'd1, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick(RD, 13'd3, 2'd1, 8'h00, 1'b0, 1'b0);
            chk("freeze_oe", int'(data_oe), 0);
        end
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("freeze_late_oe", int'(data_oe), 1);
        chk("freeze_late_data", int'(data_out), 'hA5);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("freeze_one_pulse", int'(data_oe), 0);
        tick(RD, 13'd3, 2'd1, 8'h00, 1'b0, 1'b1);
        tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(NOP, 13'd0, 2'd0, 8'h00, 1'b0, 1'b1);
            chk("rst_discard_oe", int'(data_oe), 0);
        end

        // randomized traffic against the model
        do_reset();
        tick(MRS, 13'h230, 2'd0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            rc  = r < 20 ? ACT : r < 45 ? RD : r < 70 ? WR : r < 78 ? PRE :
                  r < 85 ? NOP : r < 88 ? REF : r < 91 ? MRS : DES;
            col = 13'($urandom_range(0, 7)) | (($urandom_range(0, 6) == 0) ? 13'h400 : 13'h0);
            ra  = rc == ACT ? 13'($urandom_range(0, 3)) :
                  rc == MRS ? 13'($urandom_range(1, 4) << 4) : col;
            tick(rc, ra, 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
